data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmr_pkg.sv | 22 ++
 rtl/dmr_ram.sv | 33 +++
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmr_pkg.sv
// Shared types and defaults for the data_mem_responder slice.
// Optional byte-strobe writes are enabled by defining DMR_BYTE_STROBE_EN.
package dmr_pkg;

  localparam int DMR_WORD_W      = 32;
  localparam int DMR_DEPTH       = 64;
  localparam int DMR_WAIT_CYCLES = 2;
  localparam int DMR_CNT_W       = 4;
  localparam int DMR_BE_W        = DMR_WORD_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmr_state_t;

  // Word-index width for a given depth, never narrower than one bit.
  function automatic int dmr_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmr_ram.sv
// Single-port DEPTH x 32 storage: synchronous byte-masked write, combinational read.
// Byte masking is always present here; the top ties it to all-ones unless DMR_BYTE_STROBE_EN.
module dmr_ram
  import dmr_pkg::*;
#(
  parameter int DEPTH = DMR_DEPTH,
  parameter int AW    = dmr_idx_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DMR_BE_W-1:0]   be,
  input  logic [AW-1:0]         addr,
  input  logic [DMR_WORD_W-1:0] wdata,
  output logic [DMR_WORD_W-1:0] rdata
);

  logic [DMR_WORD_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset branch on purpose; contents must survive reset
  // and a resettable array would prevent mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DMR_BE_W; b++) begin
        if (be[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready memory responder with a fixed number of wait states per access.
// Define DMR_BYTE_STROBE_EN to add the req_be byte-strobe input.
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int DEPTH       = DMR_DEPTH,
  parameter int WAIT_CYCLES = DMR_WAIT_CYCLES
) (
  input  logic                  clk_DMR,
  input  logic                  rst_DMR,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [DMR_WORD_W-1:0] req_wdata,
`ifdef DMR_BYTE_STROBE_EN
  input  logic [DMR_BE_W-1:0]   req_be,
`endif
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DMR_WORD_W-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int                   AW       = dmr_idx_w(DEPTH);
  localparam logic [DMR_CNT_W-1:0] CNT_LOAD = DMR_CNT_W'(WAIT_CYCLES);

  dmr_state_t            state_q, state_d;
  logic [DMR_CNT_W-1:0]  cnt_q, cnt_d;
  logic                  write_q, err_q;
  logic [AW-1:0]         idx_q;
  logic [DMR_WORD_W-1:0] wdata_q;
  logic [DMR_BE_W-1:0]   be_q;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DMR_WORD_W-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;

  logic                  accept;
  logic                  enter_resp;
  logic                  addr_err;
  logic [DMR_BE_W-1:0]   req_be_i;

  // Access fields: the live request on the accept edge, the latched copy afterwards.
  logic                  acc_write, acc_err;
  logic [AW-1:0]         acc_idx;
  logic [DMR_WORD_W-1:0] acc_wdata;
  logic [DMR_BE_W-1:0]   acc_be;

  logic                  ram_we;
  logic [DMR_WORD_W-1:0] ram_rdata;

`ifdef DMR_BYTE_STROBE_EN
  assign req_be_i = req_be;
`else
  assign req_be_i = '1;
`endif

  assign accept   = (state_q == IDLE) && req_valid;
  assign addr_err = (req_addr[1:0] != 2'b00) ||
                    ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  always_comb begin
    if (accept) begin
      acc_write = req_write;
      acc_err   = addr_err;
      acc_idx   = req_addr[AW+1:2];
      acc_wdata = req_wdata;
      acc_be    = req_be_i;
    end else begin
      acc_write = write_q;
      acc_err   = err_q;
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    enter_resp   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Writes commit and read data is captured on the same edge that enters RESP.
    if (enter_resp) begin
      resp_valid_d = 1'b1;
      resp_err_d   = acc_err;
      resp_rdata_d = (acc_write || acc_err) ? '0 : ram_rdata;
    end

    ram_we      = enter_resp && acc_write && !acc_err && !rst_DMR;
    req_ready_d = (state_d == IDLE);
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_DMR) begin
    if (rst_DMR) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= acc_write;
      err_q        <= acc_err;
      idx_q        <= acc_idx;
      wdata_q      <= acc_wdata;
      be_q         <= acc_be;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  dmr_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk_DMR),
    .we    (ram_we),
    .be    (acc_be),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule
